// File: rtl/axi_rd_arb_pkg.sv
// Shared definitions for the AXI4 read-channel arbiter:
// response codes, burst codes and the arbiter FSM state type.
package axi_rd_arb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection: searches upward from ptr with wrap-around.
// Tying ptr to 0 turns it into a fixed lowest-index-wins priority arbiter.
module rr_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int unsigned NUM_MST = 2,
    localparam int unsigned PTR_W  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_MST-1:0] winner,
    output logic [PTR_W-1:0]   next_ptr
);

    logic        found;
    int unsigned idx;

    always_comb begin
        winner   = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NUM_MST; i++) begin
            idx = (32'(ptr) + i) % NUM_MST;
            if (en && !found && req[idx]) begin
                winner[idx] = 1'b1;
                next_ptr    = PTR_W'((idx + 1) % NUM_MST);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-master AXI4 read-channel arbiter: one owner at a time, held until its rlast.
// Define AXI_RD_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int unsigned NUM_MST = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ID_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MST-1:0]        m_arvalid,
    input  logic [NUM_MST*ADDR_W-1:0] m_araddr,
    input  logic [NUM_MST*ID_W-1:0]   m_arid,
    input  logic [NUM_MST*8-1:0]      m_arlen,
    input  logic [NUM_MST*3-1:0]      m_arsize,
    input  logic [NUM_MST*2-1:0]      m_arburst,
    output logic [NUM_MST-1:0]        m_arready,
    input  logic [NUM_MST-1:0]        m_rready,
    output logic [NUM_MST-1:0]        m_rvalid,
    output logic [1:0]                m_rresp,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_rlast,
    output logic [ID_W-1:0]           m_rid,
    output logic                      s_arvalid,
    output logic [ADDR_W-1:0]         s_araddr,
    output logic [ID_W-1:0]           s_arid,
    output logic [7:0]                s_arlen,
    output logic [2:0]                s_arsize,
    output logic [1:0]                s_arburst,
    input  logic                      s_arready,
    input  logic                      s_rvalid,
    input  logic [1:0]                s_rresp,
    input  logic [DATA_W-1:0]         s_rdata,
    input  logic                      s_rlast,
    input  logic [ID_W-1:0]           s_rid,
    output logic                      s_rready,
    output logic [NUM_MST-1:0]        grant,
    output logic                      busy
);

    localparam int unsigned PTR_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

    state_t             state;
    logic [NUM_MST-1:0] win;
    logic [PTR_W-1:0]   ptr;
    logic               arb_en;

    assign arb_en = (state == ST_IDLE);

`ifdef AXI_RD_ARB_RR_EN
    logic [PTR_W-1:0] ptr_next;

    rr_arbiter #(.NUM_MST(NUM_MST)) u_arb (
        .req      (m_arvalid),
        .ptr      (ptr),
        .en       (arb_en),
        .winner   (win),
        .next_ptr (ptr_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (arb_en && |m_arvalid) begin
            ptr <= ptr_next;
        end
    end
`else
    logic [PTR_W-1:0] unused_next_ptr;

    assign ptr = '0;

    rr_arbiter #(.NUM_MST(NUM_MST)) u_arb (
        .req      (m_arvalid),
        .ptr      (ptr),
        .en       (arb_en),
        .winner   (win),
        .next_ptr (unused_next_ptr)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            grant <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|m_arvalid) begin
                        grant <= win;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (s_arvalid && s_arready) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (s_rvalid && s_rready && s_rlast) begin
                        grant <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Routing follows the registered grant only; rid never steers beats.
    always_comb begin
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arid    = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        for (int unsigned i = 0; i < NUM_MST; i++) begin
            if (grant[i]) begin
                s_araddr  = m_araddr[i*ADDR_W +: ADDR_W];
                s_arid    = m_arid[i*ID_W +: ID_W];
                s_arlen   = m_arlen[i*8 +: 8];
                s_arsize  = m_arsize[i*3 +: 3];
                s_arburst = m_arburst[i*2 +: 2];
                if (state == ST_ADDR) begin
                    s_arvalid    = m_arvalid[i];
                    m_arready[i] = s_arready;
                end
                if (state == ST_DATA) begin
                    m_rvalid[i] = s_rvalid;
                    s_rready    = m_rready[i];
                end
            end
        end
    end

    assign m_rresp = s_rresp;
    assign m_rdata = s_rdata;
    assign m_rlast = s_rlast;
    assign m_rid   = s_rid;
    assign busy    = (state != ST_IDLE);

endmodule
